// File: rtl/req_clr_initiator.sv
// req_clr_initiator
//   Initiator-side driver and checker for the req/clr request-latch protocol.
//   Each accepted start runs one sequence:
//     DRIVE (req only, hold_cycles cycles) -> CLEAR (req+clr, 1 cycle)
//     -> DRAIN (both low, 1 cycle) -> IDLE.
//   The responder's registered ack must equal (req & ~clr) delayed by one
//   cycle. Every cycle in which that does not hold is counted in a
//   saturating error counter.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-high reset
//   start        in   begin a sequence (ignored while busy)
//   hold_cycles  in   req-only cycle count, latched on accepted start
//   ack_in       in   responder's registered output
//   req, clr     out  registered request / clear to the responder
//   busy         out  sequence running or final check still pending
//   done         out  one-cycle pulse; err_cnt/error are final here
//   err_cnt      out  saturating mismatch count for current/last sequence
//   error        out  sticky mismatch flag since the last accepted start
module req_clr_initiator #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] hold_cycles,
  input  logic             ack_in,
  output logic             req,
  output logic             clr,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt,
  output logic             error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CLEAR = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             exp_q;   // ack value expected this cycle
  logic             chk_q;   // this cycle's ack is to be checked
  logic             acc;     // start accepted at this edge

  // In IDLE busy reduces to chk_q: the last check of the previous
  // sequence blocks a new start for exactly one cycle.
  assign busy = (state != IDLE) | chk_q;
  assign acc  = (state == IDLE) & start & ~chk_q;

  // Sequencer. req/clr are assigned alongside each transition so they
  // are high in exactly the cycles spent in DRIVE/CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= 1'b0;
      clr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            cnt <= hold_cycles;
            if (hold_cycles != '0) begin
              state <= DRIVE;
              req   <= 1'b1;
              clr   <= 1'b0;
            end else begin
              state <= CLEAR;
              req   <= 1'b1;
              clr   <= 1'b1;
            end
          end
        end
        DRIVE: begin
          // cnt enters DRIVE >= 1, so the guard only protects against wrap.
          if (cnt != '0) cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= CLEAR;
            req   <= 1'b1;
            clr   <= 1'b1;
          end
        end
        CLEAR: begin
          state <= DRAIN;
          req   <= 1'b0;
          clr   <= 1'b0;
        end
        DRAIN: begin
          state <= IDLE;
          req   <= 1'b0;
          clr   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
          clr   <= 1'b0;
        end
      endcase
    end
  end

  // Checker. The ack for cycle k reflects req/clr of cycle k-1, and a
  // check is armed for every cycle following a non-IDLE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q   <= 1'b0;
      chk_q   <= 1'b0;
      done    <= 1'b0;
      err_cnt <= '0;
      error   <= 1'b0;
    end else begin
      exp_q <= req & ~clr;
      chk_q <= (state != IDLE);
      done  <= chk_q & (state == IDLE);
      // acc implies chk_q=0, so a clear and an increment never collide.
      if (acc) begin
        err_cnt <= '0;
        error   <= 1'b0;
      end else if (chk_q && (ack_in != exp_q)) begin
        error <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_req_clr_initiator.sv
module tb_req_clr_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] hold_cycles;
  logic       ack_in;
  logic       req, clr, busy, done, error;
  logic [3:0] err_cnt;

  int n_chk = 0;
  int n_err = 0;
  int mode;        // 0: ideal responder, 1: ack tied 0, 2: ack tied 1
  logic ack_r;

  always #5 clk = ~clk;

  // Ideal responder: registered (req & ~clr).
  always_ff @(posedge clk or posedge rst)
    if (rst) ack_r <= 1'b0;
    else     ack_r <= req & ~clr;

  always_comb begin
    ack_in = ack_r;
    if (mode == 1) ack_in = 1'b0;
    else if (mode == 2) ack_in = 1'b1;
  end

  req_clr_initiator #(.CNT_W(8), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .hold_cycles(hold_cycles),
    .ack_in(ack_in), .req(req), .clr(clr), .busy(busy), .done(done),
    .err_cnt(err_cnt), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One sequence from an idle DUT. Traces are indexed by cycle number,
  // cycle 0 being the cycle in which start is presented.
  task automatic run_seq(input int h, input int m, input string tag);
    logic [31:0] rq, cl, bs, dn, e_rq, e_cl, e_bs, e_dn;
    logic [3:0]  ec;
    logic        er;
    int          e_err;
    rq = '0; cl = '0; bs = '0; dn = '0;
    e_rq = '0; e_cl = '0; e_bs = '0; e_dn = '0;
    ec = 4'hx; er = 1'bx;
    mode = m;
    @(negedge clk);
    hold_cycles = 8'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= h + 5; k++) begin
      rq[k] = req; cl[k] = clr; bs[k] = busy; dn[k] = done;
      if (done) begin ec = err_cnt; er = error; end
      @(negedge clk);
    end
    for (int k = 1; k <= h + 5; k++) begin
      e_rq[k] = (k <= h + 1);
      e_cl[k] = (k == h + 1);
      e_bs[k] = (k <= h + 3);
      e_dn[k] = (k == h + 4);
    end
    if (m == 0)      e_err = 0;
    else if (m == 1) e_err = (h > 15) ? 15 : h;
    else             e_err = 2;
    chk({tag, "_req"},  rq, e_rq);
    chk({tag, "_clr"},  cl, e_cl);
    chk({tag, "_busy"}, bs, e_bs);
    chk({tag, "_done"}, dn, e_dn);
    chk({tag, "_errcnt"}, 32'(ec), 32'(e_err));
    chk({tag, "_error"},  32'(er), 32'(e_err != 0));
  endtask

  initial begin
    logic [31:0] rq, dn, bs, e_rq, e_dn, e_bs;
    rst = 1'b1; start = 1'b0; hold_cycles = '0; mode = 0;
    #1;
    chk("reset_outs", 32'({req, clr, busy, done, error, err_cnt}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", 32'({req, clr, busy, done, error, err_cnt}), 32'd0);

    run_seq(3, 0, "t1");
    run_seq(0, 0, "t2");
    run_seq(3, 1, "t3");
    run_seq(3, 2, "t4");
    run_seq(20, 1, "t5_sat");
    run_seq(3, 0, "t5_clear");

    // Reset in the middle of DRIVE with errors already counted.
    mode = 1;
    @(negedge clk); hold_cycles = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;      // cycle 1
    @(negedge clk);                    // cycle 2: first failing check
    @(negedge clk);                    // cycle 3
    chk("t6_pre_err", 32'(err_cnt), 32'd1);
    chk("t6_pre_req", 32'(req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_outs", 32'({req, clr, busy, done, error, err_cnt}), 32'd0);
    @(negedge clk);
    chk("t6_rst_hold", 32'({req, clr, busy, done, error, err_cnt}), 32'd0);
    rst = 1'b0;
    run_seq(3, 0, "t6");

    // start held high; hold_cycles disturbed mid-sequence.
    mode = 0;
    rq = '0; dn = '0; bs = '0; e_rq = '0; e_dn = '0; e_bs = '0;
    @(negedge clk); hold_cycles = 8'd2; start = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      rq[k] = req; dn[k] = done; bs[k] = busy;
      if (k == 2) hold_cycles = 8'd7;
      if (k == 6) hold_cycles = 8'd2;
      if (k == 7) start = 1'b0;
    end
    for (int k = 1; k <= 13; k++) begin
      e_rq[k] = (k >= 1 && k <= 3) || (k >= 7 && k <= 9);
      e_dn[k] = (k == 6) || (k == 12);
      e_bs[k] = (k >= 1 && k <= 5) || (k >= 7 && k <= 11);
    end
    chk("t7_req",  rq, e_rq);
    chk("t7_done", dn, e_dn);
    chk("t7_busy", bs, e_bs);
    chk("t7_errcnt", 32'({error, err_cnt}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
